// File: rtl/gpio_port.sv
// gpio_port: register-mapped GPIO with per-pin direction, output latch, synchronised input and edge interrupts.
// Optional macro GPIO_DEBOUNCE_EN inserts a per-pin debouncer between the synchroniser and the edge detector.
module gpio_port #(
    parameter int          NUM_PINS       = 8,
    parameter logic [23:0] BASE_ADDR      = 24'h2060,
    parameter logic [7:0]  DIR_RESET      = 8'h00,
    parameter logic [7:0]  DATA_RESET     = 8'h00,
    parameter int          DEBOUNCE_TICKS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_ce,
    input  logic                bus_write,
    input  logic                bus_read,
    input  logic [23:0]         bus_address_in,
    input  logic [7:0]          bus_data_in,
    output logic [7:0]          bus_data_out,
    input  logic [NUM_PINS-1:0] pin_in,
    output logic [NUM_PINS-1:0] pin_out,
    output logic [NUM_PINS-1:0] pin_oe,
    output logic                irq
);

    localparam logic [2:0] REG_DIR  = 3'd0;
    localparam logic [2:0] REG_DATA = 3'd1;
    localparam logic [2:0] REG_IEN  = 3'd2;
    localparam logic [2:0] REG_EDGE = 3'd3;
    localparam logic [2:0] REG_BOTH = 3'd4;
    localparam logic [2:0] REG_PEND = 3'd5;

    logic [NUM_PINS-1:0] dir_q, latch_q, ien_q, edge_q, both_q, pend_q;
    logic [NUM_PINS-1:0] s1, s2, prev, in_v;
    logic [NUM_PINS-1:0] rise, fall, det, pend_clr, wdata, rd_pins;
    logic [23:0]         addr_off;
    logic                hit, wr;
    logic [2:0]          reg_sel;
    logic                unused_bits;

    // Unsigned subtraction makes the 8-byte window work for any BASE_ADDR alignment.
    assign addr_off = bus_address_in - BASE_ADDR;
    assign hit      = (addr_off[23:3] == 21'd0);
    assign reg_sel  = addr_off[2:0];
    assign wr       = clk_ce & bus_write & hit;
    assign wdata    = bus_data_in[NUM_PINS-1:0];

    // Reads have no side effects and upper data bits are dropped on narrow builds.
    assign unused_bits = ^{bus_read, bus_data_in};

`ifdef GPIO_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [CNT_W-1:0]    db_cnt [NUM_PINS];
    logic [NUM_PINS-1:0] db_stable;

    // With a 1-bit signal, any change of s2 while counting is a return to the stable level,
    // so comparing against stable restarts the count on every new sample value.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_stable <= '0;
            // NOTE: the counter array is small control state, not a RAM, so it is reset like any other flop.
            for (int i = 0; i < NUM_PINS; i++) db_cnt[i] <= '0;
        end else if (clk_ce) begin
            for (int i = 0; i < NUM_PINS; i++) begin
                if (s2[i] == db_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_stable[i] <= s2[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign in_v = db_stable;
`else
    localparam int unused_debounce_ticks = DEBOUNCE_TICKS;

    assign in_v = s2;
`endif

    assign rise     = in_v & ~prev;
    assign fall     = ~in_v & prev;
    assign det      = (both_q & (rise | fall)) | (~both_q & ((edge_q & rise) | (~edge_q & fall)));
    assign pend_clr = (wr && reg_sel == REG_PEND) ? wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            prev    <= '0;
            dir_q   <= DIR_RESET[NUM_PINS-1:0];
            latch_q <= DATA_RESET[NUM_PINS-1:0];
            ien_q   <= '0;
            edge_q  <= '0;
            both_q  <= '0;
            pend_q  <= '0;
        end else if (clk_ce) begin
            // NOTE: non-blocking assignments so s1->s2->prev form a real shift chain.
            s1     <= pin_in;
            s2     <= s1;
            prev   <= in_v;
            // A detected edge wins over a same-tick write-1-to-clear.
            pend_q <= (pend_q & ~pend_clr) | det;
            if (wr) begin
                case (reg_sel)
                    REG_DIR:  dir_q   <= wdata;
                    REG_DATA: latch_q <= wdata;
                    REG_IEN:  ien_q   <= wdata;
                    REG_EDGE: edge_q  <= wdata;
                    REG_BOTH: both_q  <= wdata;
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves rd_pins unassigned (no latch).
        rd_pins = '0;
        case (reg_sel)
            REG_DIR:  rd_pins = dir_q;
            REG_DATA: rd_pins = (dir_q & latch_q) | (~dir_q & in_v);
            REG_IEN:  rd_pins = ien_q;
            REG_EDGE: rd_pins = edge_q;
            REG_BOTH: rd_pins = both_q;
            REG_PEND: rd_pins = pend_q;
            default:  rd_pins = '0;
        endcase
    end

    assign bus_data_out = hit ? 8'(rd_pins) : 8'h00;
    assign pin_out      = latch_q;
    assign pin_oe       = dir_q;
    assign irq          = |(pend_q & ien_q);

endmodule
